muldiv_ctrl: RTL and testbench

- Sequencing controller for the RV32M multiply/divide datapath; sits between the decode/issue stage and writeback.
- Accepts one M-extension op at a time over a valid/ready handshake.
- Multiplies complete in one cycle from registered operands. Divides and remainders use an iterative radix-2 restoring divider, one quotient bit per cycle.
- Holds the result under output backpressure. Supports pipeline flush and passes a destination tag through unchanged.

---
 rtl/muldiv_pkg.sv | 50 +++++
 rtl/muldiv_ctrl_div_iter.sv | 65 ++++++
 rtl/muldiv_ctrl.sv | 155 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and helpers for the RV32M multiply/divide block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int DIV_CYCLES   = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } muldiv_state_e;

   function automatic logic is_div(input muldiv_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic is_rem(input muldiv_op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic is_signed_x(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_y(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_ctrl_div_iter.sv
// ============================================================================
// Module      : div_iter
// Description : Unsigned radix-2 restoring divider, one quotient bit per step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_iter
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_load,
   input  logic            i_step,
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_quo,
   output logic [XLEN-1:0] o_rem,
   output logic            o_done
);

   localparam int CNT_W = $clog2(DIV_CYCLES);

   logic [XLEN-1:0]  r_rem;
   logic [XLEN-1:0]  r_quo;
   logic [XLEN-1:0]  r_dvs;
   logic [CNT_W-1:0] r_cnt;
   logic [XLEN:0]    w_rem_sh;
   logic [XLEN:0]    w_diff;

   // Partial remainder stays below the divisor, so the shifted value fits XLEN+1 bits.
   assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_dvs};
   assign o_done   = i_step && (r_cnt == '0);
   assign o_quo    = r_quo;
   assign o_rem    = r_rem;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rem <= '0;
         r_quo <= '0;
         r_dvs <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_rem <= '0;
         r_quo <= i_dividend;
         r_dvs <= i_divisor;
         r_cnt <= CNT_W'(DIV_CYCLES - 1);
      end else if (i_step) begin
         if (!w_diff[XLEN]) begin
            r_rem <= w_diff[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b1};
         end else begin
            r_rem <= w_rem_sh[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b0};
         end
         r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ============================================================================
// Module      : muldiv_ctrl
// Description : RV32M multiply/divide sequencer with handshake, flush and tag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int TAG_W = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_op,
   input  logic [XLEN-1:0]  i_x,
   input  logic [XLEN-1:0]  i_y,
   input  logic [TAG_W-1:0] i_tag,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [XLEN-1:0]  o_res,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_busy
);

   localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e    r_state, w_next;
   muldiv_op_e       r_op;
   logic [XLEN-1:0]  r_x, r_y, r_res;
   logic [TAG_W-1:0] r_tag;
   logic             r_neg_q, r_neg_r;

   muldiv_op_e       w_in_op;
   logic             w_accept, w_div_load, w_div_step, w_div_done;
   logic             w_in_sx, w_in_sy, w_y_zero, w_ovf, w_special;
   logic [XLEN-1:0]  w_abs_x, w_abs_y, w_spec_res, w_quo, w_rem;
   logic [XLEN-1:0]  w_mul_res, w_fix_res;
   logic [2*XLEN-1:0] w_mx, w_my, w_prod;

   assign w_in_op   = muldiv_op_e'(i_op);
   assign w_in_sx   = is_signed_x(w_in_op) && i_x[XLEN-1];
   assign w_in_sy   = is_signed_y(w_in_op) && i_y[XLEN-1];
   assign w_abs_x   = w_in_sx ? -i_x : i_x;
   assign w_abs_y   = w_in_sy ? -i_y : i_y;
   assign w_y_zero  = (i_y == '0);
   assign w_ovf     = is_signed_x(w_in_op) && (i_x == C_MIN_NEG) && (i_y == '1);
   assign w_special = w_y_zero || w_ovf;

   // Divide-by-zero wins over overflow; y cannot be both zero and all-ones anyway.
   always_comb begin
      w_spec_res = '0;
      if (w_y_zero)
         w_spec_res = is_rem(w_in_op) ? i_x : '1;
      else
         w_spec_res = is_rem(w_in_op) ? '0 : C_MIN_NEG;
   end

   assign w_mx   = {{XLEN{is_signed_x(r_op) && r_x[XLEN-1]}}, r_x};
   assign w_my   = {{XLEN{is_signed_y(r_op) && r_y[XLEN-1]}}, r_y};
   assign w_prod = w_mx * w_my;
   assign w_mul_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

   always_comb begin
      w_fix_res = '0;
      if (is_rem(r_op))
         w_fix_res = r_neg_r ? -w_rem : w_rem;
      else
         w_fix_res = r_neg_q ? -w_quo : w_quo;
   end

   assign w_div_step = (r_state == ST_DIV);

   div_iter #(
      .XLEN(XLEN)
   ) u_div_iter (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_div_load),
      .i_step     (w_div_step),
      .i_dividend (w_abs_x),
      .i_divisor  (w_abs_y),
      .o_quo      (w_quo),
      .o_rem      (w_rem),
      .o_done     (w_div_done)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_div_load = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_valid && !i_flush) begin
               w_accept = 1'b1;
               if (!is_div(w_in_op)) begin
                  w_next = ST_MUL;
               end else if (w_special) begin
                  w_next = ST_DONE;
               end else begin
                  w_next     = ST_DIV;
                  w_div_load = 1'b1;
               end
            end
         end
         ST_MUL:  w_next = ST_DONE;
         ST_DIV:  if (w_div_done) w_next = ST_FIX;
         ST_FIX:  w_next = ST_DONE;
         ST_DONE: if (i_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
      if (i_flush) w_next = ST_IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_op    <= OP_MUL;
         r_x     <= '0;
         r_y     <= '0;
         r_tag   <= '0;
         r_res   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (w_accept) begin
         r_op    <= w_in_op;
         r_x     <= i_x;
         r_y     <= i_y;
         r_tag   <= i_tag;
         r_neg_q <= w_in_sx ^ w_in_sy;
         r_neg_r <= w_in_sx;
         if (w_special && is_div(w_in_op)) r_res <= w_spec_res;
      end else if (!i_flush) begin
         if (r_state == ST_MUL)      r_res <= w_mul_res;
         else if (r_state == ST_FIX) r_res <= w_fix_res;
      end
   end

   assign o_ready = (r_state == ST_IDLE) && !i_flush;
   assign o_valid = (r_state == ST_DONE);
   assign o_busy  = (r_state != ST_IDLE);
   assign o_res   = r_res;
   assign o_tag   = r_tag;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Directed-vector bench for muldiv_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [2:0]  i_op = 3'b000;
   logic [31:0] i_x = '0;
   logic [31:0] i_y = '0;
   logic [4:0]  i_tag = '0;
   logic        i_flush = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic [31:0] o_res;
   logic [4:0]  o_tag;
   logic        o_busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 i_clk = ~i_clk;

   muldiv_ctrl #(.XLEN(32), .TAG_W(5)) u_dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_op    (i_op),
      .i_x     (i_x),
      .i_y     (i_y),
      .i_tag   (i_tag),
      .i_flush (i_flush),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_res   (o_res),
      .o_tag   (o_tag),
      .o_busy  (o_busy)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one op at a negedge; inputs change and outputs are sampled on negedges.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] tag,
                         input logic [31:0] exp_res, input int exp_lat, input int hold);
      int   lat;
      logic busy_ok;
      logic stable_ok;
      check_eq({name, " ready"}, 64'(o_ready), 64'd1);
      i_ready = (hold == 0);
      i_valid = 1'b1; i_op = op; i_x = x; i_y = y; i_tag = tag;
      @(negedge i_clk);
      i_valid = 1'b0; i_x = '0; i_y = '0; i_tag = '0;
      lat = 0;
      busy_ok = 1'b1;
      while (!o_valid && lat < 60) begin
         if (!o_busy || o_ready) busy_ok = 1'b0;
         @(negedge i_clk);
         lat++;
      end
      check_eq({name, " latency"}, 64'(lat), 64'(exp_lat));
      check_eq({name, " busy"}, 64'({busy_ok, o_busy}), 64'b11);
      check_eq({name, " res"}, 64'(o_res), 64'(exp_res));
      check_eq({name, " tag"}, 64'(o_tag), 64'(tag));
      if (hold > 0) begin
         stable_ok = 1'b1;
         for (int k = 0; k < hold; k++) begin
            @(negedge i_clk);
            if (!o_valid || o_ready || o_res !== exp_res || o_tag !== tag) stable_ok = 1'b0;
         end
         check_eq({name, " hold stable"}, 64'(stable_ok), 64'd1);
         i_ready = 1'b1;
      end
      @(negedge i_clk);
      check_eq({name, " post xfer"}, 64'({o_valid, o_busy, o_ready}), 64'b001);
   endtask

   initial begin
      logic seen_valid;
      #2;
      check_eq("reset outs", {30'd0, o_valid, o_busy, o_tag, o_res}, 64'd0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      run_op("MUL",    3'b000, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1,  0);
      run_op("MULHU",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 1,  0);
      run_op("MULH",   3'b001, 32'h8000_0000,  32'h8000_0000, 5'd3,  32'h4000_0000, 1,  0);
      run_op("DIV",    3'b100, 32'hFFFF_FFEC,  32'd3,         5'd4,  32'hFFFF_FFFA, 33, 0);
      run_op("REM",    3'b110, 32'hFFFF_FFEC,  32'd3,         5'd5,  32'hFFFF_FFFE, 33, 0);
      run_op("REMpos", 3'b110, 32'd20,         32'hFFFF_FFFD, 5'd6,  32'd2,         33, 0);
      run_op("DIVU0",  3'b101, 32'd100,        32'd0,         5'd7,  32'hFFFF_FFFF, 0,  0);
      run_op("REMU0",  3'b111, 32'd5,          32'd0,         5'd8,  32'd5,         0,  0);
      run_op("REMovf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'd0,         0,  0);
      run_op("DIVovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 0,  0);
      run_op("DIVUbp", 3'b101, 32'd1000,       32'd7,         5'd11, 32'd142,       33, 5);

      // Flush on E10 of a divide.
      i_valid = 1'b1; i_op = 3'b100; i_x = 32'd1000; i_y = 32'd3; i_tag = 5'd12;
      @(negedge i_clk);
      i_valid = 1'b0;
      repeat (9) @(negedge i_clk);
      i_flush = 1'b1;
      #1;
      check_eq("flush ready low", 64'(o_ready), 64'd0);
      @(negedge i_clk);
      i_flush = 1'b0;
      check_eq("flush idle", 64'({o_busy, o_valid}), 64'd0);
      seen_valid = 1'b0;
      repeat (40) begin
         @(negedge i_clk);
         if (o_valid) seen_valid = 1'b1;
      end
      check_eq("flush no valid", 64'(seen_valid), 64'd0);
      run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd13, 32'hFFFF_FFFF, 1, 0);

      // Asynchronous reset in the middle of a divide.
      i_valid = 1'b1; i_op = 3'b101; i_x = 32'd999; i_y = 32'd4; i_tag = 5'd14;
      @(negedge i_clk);
      i_valid = 1'b0;
      repeat (5) @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      check_eq("async rst", {30'd0, o_valid, o_busy, o_tag, o_res}, 64'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      run_op("REMU", 3'b111, 32'd17, 32'd5, 5'd15, 32'd2, 33, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
